// File: rtl/crc32_pkg.sv
// ============================================================================
// Module : crc32_pkg
// Brief  : Shared CRC32 constants, byte-step function and checker FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package crc32_pkg;

   localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT  = 32'hFFFFFFFF;
   localparam int          CRC32_CNT_W = 16;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PAYLOAD = 1'b1
   } crc32_state_t;

   // MSB-first, non-reflected: bit 7 of the byte is the first serial bit.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {data, 24'h000000};
      for (int i = 0; i < 8; i++) begin
         c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_word_step.sv
// ============================================================================
// Module : crc32_word_step
// Brief  : Combinational CRC32 update over one 32-bit word, MSB byte first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module crc32_word_step
   import crc32_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [31:0] data,
   output logic [31:0] crc_out
);

   logic [31:0] w_b3;
   logic [31:0] w_b2;
   logic [31:0] w_b1;

   always_comb begin
      w_b3    = crc32_byte(crc_in, data[31:24]);
      w_b2    = crc32_byte(w_b3,   data[23:16]);
      w_b1    = crc32_byte(w_b2,   data[15:8]);
      crc_out = crc32_byte(w_b1,   data[7:0]);
   end

endmodule

`default_nettype wire

// File: rtl/crc32_frame_check.sv
// ============================================================================
// Module : crc32_frame_check
// Brief  : Receive-side CRC32 frame checker (payload words + one FCS word).
//          Frame counters present only when CRC32_FRAME_CHECK_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module crc32_frame_check
   import crc32_pkg::*;
#(
   parameter int MAX_WORDS = 1024
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_sop,
   input  logic                   in_eop,
   input  logic [31:0]            in_data,
   output logic                   done,
   output logic                   crc_ok,
   output logic [31:0]            crc_calc,
   output logic                   err_proto,
   output logic                   err_long,
   output logic [CRC32_CNT_W-1:0] cnt_good,
   output logic [CRC32_CNT_W-1:0] cnt_bad
);

   localparam int                  c_wcnt_w   = $clog2(MAX_WORDS + 2);
   localparam logic [c_wcnt_w-1:0] c_wcnt_max = c_wcnt_w'(MAX_WORDS + 1);
   localparam logic [c_wcnt_w-1:0] c_wcnt_one = c_wcnt_w'(1);

   logic                r_valid;
   logic                r_sop;
   logic                r_eop;
   logic [31:0]         r_data;

   crc32_state_t        r_state;
   crc32_state_t        w_state_nxt;
   logic [31:0]         r_crc;
   logic [31:0]         w_crc_nxt;
   logic [c_wcnt_w-1:0] r_wcnt;
   logic [c_wcnt_w-1:0] w_wcnt_nxt;

   logic [31:0]         w_step_base;
   logic [31:0]         w_crc_step;
   logic                w_done;
   logic                w_proto;
   logic                w_long;
   logic                w_match;

   logic                r_done;
   logic                r_crc_ok;
   logic [31:0]         r_crc_calc;
   logic                r_err_proto;
   logic                r_err_long;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_data  <= 32'h0;
      end else begin
         r_valid <= in_valid;
         r_sop   <= in_sop;
         r_eop   <= in_eop;
         r_data  <= in_data;
      end
   end

   // A sop always restarts from the init value, even when abandoning a frame.
   assign w_step_base = (r_state == ST_PAYLOAD && !r_sop) ? r_crc : CRC32_INIT;

   crc32_word_step u_step (
      .crc_in  (w_step_base),
      .data    (r_data),
      .crc_out (w_crc_step)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_crc_nxt   = r_crc;
      w_wcnt_nxt  = r_wcnt;
      w_done      = 1'b0;
      w_proto     = 1'b0;
      w_long      = 1'b0;
      w_match     = 1'b0;
      if (r_valid) begin
         if (r_state == ST_PAYLOAD && !r_sop && r_eop) begin
            w_done      = 1'b1;
            w_match     = (r_data == r_crc);
            w_long      = (r_wcnt == c_wcnt_max);
            w_state_nxt = ST_IDLE;
            w_crc_nxt   = CRC32_INIT;
            w_wcnt_nxt  = '0;
         end else if (r_state == ST_PAYLOAD && !r_sop) begin
            w_crc_nxt = w_crc_step;
            if (r_wcnt != c_wcnt_max) begin
               w_wcnt_nxt = r_wcnt + c_wcnt_one;
            end
         end else begin
            if (r_state == ST_PAYLOAD) begin
               w_proto = 1'b1;
            end
            if (!r_sop || r_eop) begin
               w_proto     = 1'b1;
               w_state_nxt = ST_IDLE;
               w_crc_nxt   = CRC32_INIT;
               w_wcnt_nxt  = '0;
            end else begin
               w_state_nxt = ST_PAYLOAD;
               w_crc_nxt   = w_crc_step;
               w_wcnt_nxt  = c_wcnt_one;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_crc       <= CRC32_INIT;
         r_wcnt      <= '0;
         r_done      <= 1'b0;
         r_err_proto <= 1'b0;
         r_crc_ok    <= 1'b0;
         r_err_long  <= 1'b0;
         r_crc_calc  <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_crc       <= w_crc_nxt;
         r_wcnt      <= w_wcnt_nxt;
         r_done      <= w_done;
         r_err_proto <= w_proto;
         if (w_done) begin
            r_crc_ok   <= w_match & ~w_long;
            r_err_long <= w_long;
            r_crc_calc <= r_crc;
         end
      end
   end

   assign done      = r_done;
   assign crc_ok    = r_crc_ok;
   assign crc_calc  = r_crc_calc;
   assign err_proto = r_err_proto;
   assign err_long  = r_err_long;

`ifdef CRC32_FRAME_CHECK_STATS_EN
   logic [CRC32_CNT_W-1:0] r_cnt_good;
   logic [CRC32_CNT_W-1:0] r_cnt_bad;

   // Counters update from the stage-2 verdict so they are current alongside done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt_good <= '0;
         r_cnt_bad  <= '0;
      end else if (w_done) begin
         if (w_match && !w_long) begin
            if (r_cnt_good != '1) begin
               r_cnt_good <= r_cnt_good + 1'b1;
            end
         end else if (r_cnt_bad != '1) begin
            r_cnt_bad <= r_cnt_bad + 1'b1;
         end
      end
   end

   assign cnt_good = r_cnt_good;
   assign cnt_bad  = r_cnt_bad;
`else
   assign cnt_good = '0;
   assign cnt_bad  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc32_frame_check.sv
// ============================================================================
// Module : tb_crc32_frame_check
// Brief  : Directed self-checking bench for crc32_frame_check.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_crc32_frame_check;

   localparam int          MAXW = 8;
   localparam logic [31:0] INIT = 32'hFFFFFFFF;
`ifdef CRC32_FRAME_CHECK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_sop;
   logic        in_eop;
   logic [31:0] in_data;
   logic        done;
   logic        crc_ok;
   logic [31:0] crc_calc;
   logic        err_proto;
   logic        err_long;
   logic [15:0] cnt_good;
   logic [15:0] cnt_bad;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_okdone = 0;
   int n_proto = 0;
   logic [31:0] g_crc;

   always #5 clk = ~clk;

   crc32_frame_check #(.MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_data(in_data), .done(done), .crc_ok(crc_ok), .crc_calc(crc_calc),
      .err_proto(err_proto), .err_long(err_long), .cnt_good(cnt_good), .cnt_bad(cnt_bad)
   );

   always @(negedge clk) begin
      if (done === 1'b1) n_done++;
      if (done === 1'b1 && crc_ok === 1'b1) n_okdone++;
      if (err_proto === 1'b1) n_proto++;
   end

   // Bit-serial reference: one data bit per shift, word MSB first.
   function automatic logic [31:0] m_step(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 31; i >= 0; i--) begin
         fb = r[31] ^ d[i];
         r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
      in_valid = v; in_sop = s; in_eop = e; in_data = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
      n_done = 0; n_okdone = 0; n_proto = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle(3);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (crc_ok !== 1'b0) begin n_bad++; $display("FAIL rst_crc_ok: got %b want 0", crc_ok); end
      n_cmp++; if (crc_calc !== 32'h0) begin n_bad++; $display("FAIL rst_crc_calc: got %h want 0", crc_calc); end
      n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL rst_err_proto: got %b want 0", err_proto); end
      n_cmp++; if (err_long !== 1'b0) begin n_bad++; $display("FAIL rst_err_long: got %b want 0", err_long); end
      n_cmp++; if (cnt_good !== 16'h0) begin n_bad++; $display("FAIL rst_cnt_good: got %h want 0", cnt_good); end
      n_cmp++; if (cnt_bad !== 16'h0) begin n_bad++; $display("FAIL rst_cnt_bad: got %h want 0", cnt_bad); end
      rst = 1'b1;
      idle(1);
   endtask

   task automatic test_good_frame();
      do_reset();
      g_crc = m_step(m_step(INIT, 32'h00000000), 32'h11223344);
      drive(1'b1, 1'b1, 1'b0, 32'h00000000);
      drive(1'b1, 1'b0, 1'b0, 32'h11223344);
      drive(1'b1, 1'b0, 1'b1, g_crc);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL good_done_early: got %b want 0", done); end
      idle(1);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL good_done: got %b want 1", done); end
      n_cmp++; if (crc_ok !== 1'b1) begin n_bad++; $display("FAIL good_crc_ok: got %b want 1", crc_ok); end
      n_cmp++; if (crc_calc !== g_crc) begin n_bad++; $display("FAIL good_crc_calc: got %h want %h", crc_calc, g_crc); end
      n_cmp++; if (err_long !== 1'b0) begin n_bad++; $display("FAIL good_err_long: got %b want 0", err_long); end
      n_cmp++; if (cnt_good !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL good_cnt_good: got %h want %h", cnt_good, (STATS ? 16'd1 : 16'd0)); end
      idle(1);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL good_done_pulse: got %b want 0", done); end
      n_cmp++; if (crc_ok !== 1'b1) begin n_bad++; $display("FAIL good_crc_ok_held: got %b want 1", crc_ok); end
   endtask

   task automatic test_bad_fcs();
      drive(1'b1, 1'b1, 1'b0, 32'h00000000);
      drive(1'b1, 1'b0, 1'b0, 32'h11223344);
      drive(1'b1, 1'b0, 1'b1, g_crc ^ 32'h1);
      idle(1);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bad_done: got %b want 1", done); end
      n_cmp++; if (crc_ok !== 1'b0) begin n_bad++; $display("FAIL bad_crc_ok: got %b want 0", crc_ok); end
      n_cmp++; if (crc_calc !== g_crc) begin n_bad++; $display("FAIL bad_crc_calc: got %h want %h", crc_calc, g_crc); end
      n_cmp++; if (cnt_bad !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL bad_cnt_bad: got %h want %h", cnt_bad, (STATS ? 16'd1 : 16'd0)); end
      n_cmp++; if (cnt_good !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL bad_cnt_good: got %h want %h", cnt_good, (STATS ? 16'd1 : 16'd0)); end
      idle(2);
   endtask

   task automatic test_proto();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
      n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL proto_early: got %b want 0", err_proto); end
      idle(1);
      n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL proto_nosop: got %b want 1", err_proto); end
      drive(1'b1, 1'b1, 1'b1, 32'h12345678);
      idle(1);
      n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL proto_zero_len: got %b want 1", err_proto); end
      idle(3);
      n_cmp++; if (n_proto !== 2) begin n_bad++; $display("FAIL proto_pulses: got %0d want 2", n_proto); end
      n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL proto_no_done: got %0d want 0", n_done); end
      n_cmp++; if (cnt_good !== 16'h0 || cnt_bad !== 16'h0) begin n_bad++; $display("FAIL proto_counters: got %h/%h want 0/0", cnt_good, cnt_bad); end
   endtask

   task automatic test_restart();
      logic [31:0] exp;
      do_reset();
      exp = m_step(m_step(INIT, 32'hCAFEF00D), 32'h0BADBEEF);
      drive(1'b1, 1'b1, 1'b0, 32'h01020304);
      drive(1'b1, 1'b0, 1'b0, 32'h05060708);
      drive(1'b1, 1'b1, 1'b0, 32'hCAFEF00D);
      drive(1'b1, 1'b0, 1'b0, 32'h0BADBEEF);
      drive(1'b1, 1'b0, 1'b1, exp);
      idle(3);
      n_cmp++; if (n_proto !== 1) begin n_bad++; $display("FAIL restart_proto: got %0d want 1", n_proto); end
      n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL restart_done: got %0d want 1", n_done); end
      n_cmp++; if (crc_ok !== 1'b1) begin n_bad++; $display("FAIL restart_crc_ok: got %b want 1", crc_ok); end
      n_cmp++; if (crc_calc !== exp) begin n_bad++; $display("FAIL restart_crc_calc: got %h want %h", crc_calc, exp); end
      n_cmp++; if (cnt_good !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL restart_cnt_good: got %h want %h", cnt_good, (STATS ? 16'd1 : 16'd0)); end
   endtask

   task automatic test_long();
      logic [31:0] exp;
      do_reset();
      exp = INIT;
      for (int i = 0; i < MAXW; i++) begin
         drive(1'b1, (i == 0), 1'b0, 32'h01010101 * (i + 1));
         exp = m_step(exp, 32'h01010101 * (i + 1));
      end
      drive(1'b1, 1'b0, 1'b1, exp);
      idle(1);
      n_cmp++; if (done !== 1'b1 || err_long !== 1'b0 || crc_ok !== 1'b1) begin n_bad++; $display("FAIL max_len: got done=%b long=%b ok=%b want 1/0/1", done, err_long, crc_ok); end
      exp = INIT;
      for (int i = 0; i < MAXW + 1; i++) begin
         drive(1'b1, (i == 0), 1'b0, 32'h10203040 ^ i);
         exp = m_step(exp, 32'h10203040 ^ i);
      end
      drive(1'b1, 1'b0, 1'b1, exp);
      idle(1);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL long_done: got %b want 1", done); end
      n_cmp++; if (err_long !== 1'b1) begin n_bad++; $display("FAIL long_err_long: got %b want 1", err_long); end
      n_cmp++; if (crc_ok !== 1'b0) begin n_bad++; $display("FAIL long_crc_ok: got %b want 0", crc_ok); end
      n_cmp++; if (crc_calc !== exp) begin n_bad++; $display("FAIL long_crc_calc: got %h want %h", crc_calc, exp); end
      n_cmp++; if (cnt_bad !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL long_cnt_bad: got %h want %h", cnt_bad, (STATS ? 16'd1 : 16'd0)); end
      drive(1'b1, 1'b1, 1'b0, 32'h11111111);
      drive(1'b1, 1'b0, 1'b0, 32'h22222222);
      rst = 1'b0;
      idle(1);
      n_cmp++; if (done !== 1'b0 || crc_ok !== 1'b0 || err_long !== 1'b0 || err_proto !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got %b%b%b%b want 0000", done, crc_ok, err_long, err_proto); end
      n_cmp++; if (crc_calc !== 32'h0 || cnt_good !== 16'h0 || cnt_bad !== 16'h0) begin n_bad++; $display("FAIL midrst_values: got %h/%h/%h want 0/0/0", crc_calc, cnt_good, cnt_bad); end
      rst = 1'b1;
      n_done = 0;
      exp = m_step(INIT, 32'h33333333);
      drive(1'b1, 1'b0, 1'b1, 32'h44444444);
      drive(1'b1, 1'b1, 1'b0, 32'h33333333);
      drive(1'b1, 1'b0, 1'b1, exp);
      idle(1);
      n_cmp++; if (done !== 1'b1 || crc_ok !== 1'b1 || err_long !== 1'b0) begin n_bad++; $display("FAIL postrst_frame: got done=%b ok=%b long=%b want 1/1/0", done, crc_ok, err_long); end
      n_cmp++; if (crc_calc !== exp) begin n_bad++; $display("FAIL postrst_crc_calc: got %h want %h", crc_calc, exp); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      do_reset();
`ifdef CRC32_FRAME_CHECK_STATS_EN
      force dut.r_cnt_good = 16'hFFFD;
      idle(1);
      release dut.r_cnt_good;
`endif
      for (int i = 0; i < 40; i++) begin
         w = 32'hDEAD0000 + i;
         drive(1'b1, 1'b1, 1'b0, w);
         if (i % 5 == 4) idle(1);
         drive(1'b1, 1'b0, 1'b1, m_step(INIT, w));
         if (i % 3 == 2) idle(1);
      end
      idle(3);
      n_cmp++; if (n_done !== 40) begin n_bad++; $display("FAIL b2b_done: got %0d want 40", n_done); end
      n_cmp++; if (n_okdone !== 40) begin n_bad++; $display("FAIL b2b_ok: got %0d want 40", n_okdone); end
      n_cmp++; if (n_proto !== 0) begin n_bad++; $display("FAIL b2b_proto: got %0d want 0", n_proto); end
      n_cmp++; if (cnt_good !== (STATS ? 16'hFFFF : 16'h0)) begin n_bad++; $display("FAIL b2b_cnt_good: got %h want %h", cnt_good, (STATS ? 16'hFFFF : 16'h0)); end
      n_cmp++; if (cnt_bad !== 16'h0) begin n_bad++; $display("FAIL b2b_cnt_bad: got %h want 0", cnt_bad); end
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 32'h0;
      test_reset();
      test_good_frame();
      test_bad_fcs();
      test_proto();
      test_restart();
      test_long();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/crc32_frame_check.md
# crc32_frame_check

Receive-side CRC32 checker for the team's 32-bit word stream. Accepts framed words (payload followed by one FCS word), recomputes CRC32 over the payload with the same byte order, polynomial and init value as our CRC32 generator, and reports a per-frame good/bad verdict. Sits after the link deframer, before the payload consumer.

## Interface
- `MAX_WORDS`, default 1024: maximum payload words per frame; longer frames are flagged `err_long`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous assert, active-low; deassert synchronised upstream.
- `in_valid` in 1: word qualifier; no backpressure, one word per cycle.
- `in_sop` in 1: first payload word of frame, qualified by `in_valid`.
- `in_eop` in 1: word is the FCS word, qualified by `in_valid`.
- `in_data` in 32: payload or FCS word.
- `done` out 1: one-cycle pulse, verdict valid.
- `crc_ok` out 1: FCS matched; valid with `done`, held until next `done`.
- `crc_calc` out 32: computed CRC at FCS time; held until next `done`.
- `err_proto` out 1: one-cycle pulse on protocol violation.
- `err_long` out 1: valid with `done`; payload exceeded `MAX_WORDS`.
- `cnt_good` out 16, `cnt_bad` out 16: saturating frame counters.

## Operation
- CRC: polynomial 0x04C11DB7, init 0xFFFFFFFF, no final XOR, no output reflection. Per word, bytes are processed in the order `in_data[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`; within a byte, bit 7 is first serial bit.
- FSM states: IDLE, PAYLOAD.
  - IDLE: `in_valid & in_sop & ~in_eop` -> load CRC register with the step of 0xFFFFFFFF over `in_data`, word count = 1, go to PAYLOAD. `in_valid & ~in_sop` -> `err_proto` pulse, word ignored. `in_valid & in_sop & in_eop` (zero-length payload) -> `err_proto`, stay IDLE.
  - PAYLOAD: `in_valid & ~in_eop & ~in_sop` -> step CRC, count+1 (count saturates at `MAX_WORDS`+1). `in_valid & in_eop` -> compare `in_data` with CRC register, issue verdict, go IDLE. `in_valid & in_sop` -> `err_proto`, abandon current frame (no `done`), restart as IDLE+sop in the same cycle.
  - `in_valid` low: no state change, gaps allowed anywhere.
- `crc_ok` = (FCS == CRC register) & ~`err_long`.
- Counters: `cnt_good` increments on `done & crc_ok`, `cnt_bad` on `done & ~crc_ok`; both saturate at 0xFFFF; abandoned frames count in neither.
- Reset: FSM IDLE, CRC register 0xFFFFFFFF, count 0, `done`/`err_proto`/`crc_ok`/`err_long` 0, `crc_calc` 0, counters 0. Reset mid-frame discards the frame silently.

## Timing
- Stage 1: input register (`in_*` sampled). Stage 2: CRC step/compare, outputs registered.
- FCS word presented in cycle n -> `done` high in cycle n+2; `err_proto` likewise n+2.
- Back-to-back frames: next `sop` may arrive in cycle n+1 after an `eop` in cycle n; full throughput, no bubbles.
- Critical path: four chained byte steps (32-bit-wide XOR tree) in stage 2 only.

## Configuration
- `CRC32_FRAME_CHECK_STATS_EN`: defined -> `cnt_good`/`cnt_bad` implemented as above. Undefined -> counter logic removed, both ports tied to 0; verdict outputs unchanged.

## Structure
- `crc32_pkg`: `CRC32_POLY`, `CRC32_INIT`, byte-step function `crc32_byte`, FSM state enum, counter width constant.
- One sub-module: `crc32_word_step` (combinational, 32-bit data + 32-bit CRC in, next CRC out, chaining four `crc32_byte` calls), shared with the generator.

## Test plan
- Single frame of payload words 0x00000000, 0x11223344 with FCS = model CRC -> `done` at n+2, `crc_ok`=1, `crc_calc`=FCS, `cnt_good`=1.
- Same frame with FCS bit 0 flipped -> `crc_ok`=0, `crc_calc` unchanged from good case, `cnt_bad`=1.
- Word with `in_valid` but no `sop` in IDLE, then `sop`+`eop` same cycle -> two `err_proto` pulses, no `done`, counters 0.
- `sop` at word 3 of an open frame, then 2-word valid frame -> one `err_proto`, one `done` with `crc_ok`=1 for the second frame only.
- Frame of `MAX_WORDS`+1 payload words with correct FCS -> `done`, `err_long`=1, `crc_ok`=0; `rst` asserted mid-frame -> all outputs 0, following good frame passes.
- 0x10000 good back-to-back frames with `in_valid` gaps, macro defined -> `cnt_good` holds 0xFFFF; macro undefined -> both counters read 0.
